// File: rtl/bytewrite_ram_master.sv
// rtl/bytewrite_ram_master.sv - request/response initiator for one port of a byte-write NO_CHANGE BRAM
// Define BWRAM_MASTER_OREG_EN when the RAM has an output register (read latency 2 instead of 1).
module bytewrite_ram_master #(
    parameter int NUM_COL    = 4,
    parameter int COL_WIDTH  = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = NUM_COL * COL_WIDTH,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [NUM_COL-1:0]    req_be,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  ram_en,
    output logic [NUM_COL-1:0]    ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic                  busy
);

`ifdef BWRAM_MASTER_OREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int PW = $clog2(RSP_DEPTH);
    localparam int CW = $clog2(RSP_DEPTH + 1);

    logic [LAT-1:0]        rd_pipe;
    logic [DATA_WIDTH-1:0] fifo_mem [RSP_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         fifo_count;
    logic [CW-1:0]         used;
    logic [CW-1:0]         used_next;
    logic [CW-1:0]         inflight;
    logic                  ready_q;
    logic                  accept;
    logic                  rd_issue;
    logic                  wr_issue;
    logic                  push;
    logic                  pop;

    assign accept   = req_valid & ready_q;
    assign rd_issue = accept & ~req_we;
    // An all-zero strobe must not enable the port, or NO_CHANGE would perform a read.
    assign wr_issue = accept & req_we & (|req_be);

    assign ram_en   = rd_issue | wr_issue;
    assign ram_we   = wr_issue ? req_be : '0;
    assign ram_addr = req_addr;
    assign ram_din  = req_wdata;

    assign push      = rd_pipe[LAT-1];
    assign pop       = rsp_valid & rsp_ready;
    assign rsp_valid = (fifo_count != '0);
    assign rsp_rdata = fifo_mem[rd_ptr];
    assign req_ready = ready_q;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < LAT; i++) begin
            inflight = inflight + CW'(rd_pipe[i]);
        end
    end

    assign busy = (inflight != '0) | (fifo_count != '0);

    // Credits cover both in-flight reads and buffered responses; a push only moves a credit between them.
    assign used_next = used + CW'(rd_issue) - CW'(pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pipe    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            used       <= '0;
            ready_q    <= 1'b0;
        end else begin
`ifdef BWRAM_MASTER_OREG_EN
            rd_pipe <= {rd_pipe[0], rd_issue};
`else
            rd_pipe <= rd_issue;
`endif
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
            used       <= used_next;
            ready_q    <= (used_next < CW'(RSP_DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= ram_dout;
        end
    end

`ifndef SYNTHESIS
    fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (fifo_count == CW'(RSP_DEPTH))));
`endif

endmodule

// File: tb/tb_bytewrite_ram_master.sv
// tb/tb_bytewrite_ram_master.sv - directed bench for bytewrite_ram_master with a byte-write NO_CHANGE RAM model
module tb_bytewrite_ram_master;

`ifdef BWRAM_MASTER_OREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [3:0]  req_be;
    logic [9:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [9:0]  ram_addr;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;
    logic        busy;

    int total = 0;
    int passed = 0;

    bytewrite_ram_master #(.RSP_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_be(req_be),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout), .busy(busy)
    );

    always #5 clk = ~clk;

    // Byte-write RAM, NO_CHANGE: output only updates on enabled non-write cycles.
    logic [31:0] mem [1024];
    logic [31:0] dout1;
    logic [31:0] dout2;
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        dout1 = 32'h0;
        dout2 = 32'h0;
    end
    always @(posedge clk) begin
        if (ram_en) begin
            for (int c = 0; c < 4; c++) begin
                if (ram_we[c]) mem[ram_addr][c*8 +: 8] <= ram_din[c*8 +: 8];
            end
            if (ram_we == 4'b0000) dout1 <= mem[ram_addr];
        end
        dout2 <= dout1;
    end
    assign ram_dout = (LAT == 2) ? dout2 : dout1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic we, input logic [3:0] be, input logic [9:0] addr,
                        input logic [31:0] wd, output logic ok, output logic en_seen,
                        output logic [3:0] we_seen);
        int n;
        req_valid = 1'b1; req_we = we; req_be = be; req_addr = addr; req_wdata = wd;
        #1;
        n = 0;
        while (!req_ready && n < 50) begin
            step();
            n++;
        end
        ok = req_ready;
        en_seen = ram_en;
        we_seen = ram_we;
        step();
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int cycles);
        cycles = 0;
        #1;
        while (!rsp_valid && cycles < 50) begin
            step();
            #1;
            cycles++;
        end
    endtask

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic        ok;
        logic        en;
        logic [3:0]  wes;
        int          cyc;
        int          addr_next;
        int          op;
        int          drops;
        int          bad;
        int          seen;
        logic [31:0] got[$];
        logic [31:0] expq[$];

        vecs[0] = '{1'b1, 4'b1111, 10'h005, 32'h1122_3344, 32'h0};
        vecs[1] = '{1'b0, 4'b0000, 10'h005, 32'h0,         32'h1122_3344};
        vecs[2] = '{1'b1, 4'b1111, 10'h010, 32'hAABB_CCDD, 32'h0};
        vecs[3] = '{1'b1, 4'b0001, 10'h010, 32'h0000_0055, 32'h0};
        vecs[4] = '{1'b0, 4'b1111, 10'h010, 32'h0,         32'hAABB_CC55};
        vecs[5] = '{1'b1, 4'b0000, 10'h010, 32'hFFFF_FFFF, 32'h0};
        vecs[6] = '{1'b0, 4'b0000, 10'h010, 32'h0,         32'hAABB_CC55};
        vecs[7] = '{1'b1, 4'b1010, 10'h020, 32'h1234_5678, 32'h0};
        vecs[8] = '{1'b0, 4'b0000, 10'h020, 32'h0,         32'h1200_5600};

        rst = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_be = 4'hF;
        req_addr = 10'h0; req_wdata = 32'h0; rsp_ready = 1'b1;
        step(); step(); step();
        #1;
        chk("reset_req_ready", {31'b0, req_ready}, 32'd0);
        chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_ram_en", {31'b0, ram_en}, 32'd0);
        chk("reset_ram_we", {28'b0, ram_we}, 32'd0);
        rst = 1'b0; req_valid = 1'b0;
        step();
        #1;
        chk("ready_after_reset", {31'b0, req_ready}, 32'd1);

        for (int i = 0; i < 9; i++) begin
            send(vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata, ok, en, wes);
            chk($sformatf("v%0d_accept", i), {31'b0, ok}, 32'd1);
            chk($sformatf("v%0d_ram_en", i), {31'b0, en},
                (vecs[i].we && vecs[i].be == 4'b0000) ? 32'd0 : 32'd1);
            chk($sformatf("v%0d_ram_we", i), {28'b0, wes}, vecs[i].we ? {28'b0, vecs[i].be} : 32'd0);
            if (!vecs[i].we) begin
                wait_rsp(cyc);
                chk($sformatf("v%0d_latency", i), cyc, LAT);
                chk($sformatf("v%0d_rdata", i), rsp_rdata, vecs[i].exp);
            end
            step(); step(); step();
            #1;
            chk($sformatf("v%0d_idle_rsp_valid", i), {31'b0, rsp_valid}, 32'd0);
            chk($sformatf("v%0d_idle_busy", i), {31'b0, busy}, 32'd0);
        end

        // Backpressure: fill addresses 0..7, then read them with the consumer stalled.
        for (int i = 0; i < 8; i++) begin
            send(1'b1, 4'hF, 10'(i), 32'hA0A0_0000 + i, ok, en, wes);
        end
        addr_next = 0;
        got.delete();
        req_we = 1'b0;
        for (int c = 0; c < 40; c++) begin
            req_valid = (addr_next < 8);
            req_addr = 10'(addr_next);
            rsp_ready = (c >= 10);
            #1;
            if (c == 9) begin
                chk("bp_accepted", addr_next, DEPTH);
                chk("bp_ready_low", {31'b0, req_ready}, 32'd0);
                chk("bp_rsp_valid_held", {31'b0, rsp_valid}, 32'd1);
                chk("bp_head_stable", rsp_rdata, 32'hA0A0_0000);
            end
            if (req_valid && req_ready) addr_next++;
            if (rsp_valid && rsp_ready) got.push_back(rsp_rdata);
            step();
        end
        req_valid = 1'b0;
        chk("bp_rsp_count", got.size(), 8);
        bad = 0;
        for (int i = 0; i < got.size(); i++) begin
            if (got[i] !== 32'hA0A0_0000 + i) bad++;
        end
        chk("bp_rsp_order", bad, 0);

        // Streaming: alternating write/read of the same address, one request per cycle.
        op = 0; drops = 0;
        got.delete(); expq.delete();
        rsp_ready = 1'b1;
        for (int c = 0; c < 80; c++) begin
            if (op < 64) begin
                req_valid = 1'b1;
                req_we = (op % 2 == 0);
                req_be = 4'hF;
                req_addr = 10'h100 + 10'(op / 2);
                req_wdata = 32'h5A00_0000 ^ (32'(op / 2) * 32'h0001_0203);
            end else begin
                req_valid = 1'b0;
            end
            #1;
            if (op < 64 && !req_ready) drops++;
            if (req_valid && req_ready) begin
                if (req_we) expq.push_back(req_wdata);
                op++;
            end
            if (rsp_valid && rsp_ready) got.push_back(rsp_rdata);
            step();
        end
        chk("stream_ready_drops", drops, 0);
        chk("stream_ops", op, 64);
        chk("stream_rsp_count", got.size(), 32);
        bad = 0;
        for (int i = 0; i < got.size() && i < expq.size(); i++) begin
            if (got[i] !== expq[i]) bad++;
        end
        chk("stream_rdata", bad, 0);

        // Reset with reads pending in the pipeline and the FIFO.
        rsp_ready = 1'b0;
        req_we = 1'b0;
        addr_next = 0;
        for (int c = 0; c < 3; c++) begin
            req_valid = 1'b1;
            req_addr = 10'(addr_next);
            #1;
            if (req_ready) addr_next++;
            step();
        end
        req_valid = 1'b0;
        #1;
        chk("mid_reads_issued", addr_next, 3);
        chk("mid_busy_before", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        step();
        #1;
        chk("mid_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("mid_busy", {31'b0, busy}, 32'd0);
        rst = 1'b0;
        rsp_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            #1;
            if (rsp_valid) seen++;
        end
        chk("mid_no_stale_rsp", seen, 0);
        chk("mid_ready_restored", {31'b0, req_ready}, 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
